// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB4 master bridge.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DERR
  } apb_state_e;

  localparam logic [2:0] PPROT_PRIV   = 3'b001;
  localparam logic [2:0] PPROT_NONSEC = 3'b010;
  localparam logic [2:0] PPROT_INSTR  = 3'b100;

  // Width of the completer index taken from the top of the address.
  function automatic int unsigned slv_sel_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_resp_mux.sv
// Selects PRDATA/PREADY/PSLVERR of the addressed completer; purely combinational.
module apb_resp_mux
  import apb_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 2,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned SEL_W      = 1
) (
  input  logic [SEL_W-1:0]             sel_idx,
  input  logic [NUM_SLAVES*DATA_W-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]        pready,
  input  logic [NUM_SLAVES-1:0]        pslverr,
  output logic [DATA_W-1:0]            rdata,
  output logic                         ready,
  output logic                         slverr
);

  always_comb begin
    rdata  = '0;
    ready  = 1'b0;
    slverr = 1'b0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (sel_idx == SEL_W'(i)) begin
        rdata  = prdata[i*DATA_W +: DATA_W];
        ready  = pready[i];
        slverr = pslverr[i];
      end
    end
  end

endmodule

// File: rtl/apb_master_mux.sv
// APB4 master bridge: host valid/ready requests onto one shared APB bus with
// address-decoded completer select, wait-state timeout and back-to-back transfers.
module apb_master_mux
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NUM_SLAVES  = 2,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                         PCLK,
  input  logic                         PRESETn,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  input  logic [DATA_W/8-1:0]          req_strb,
  input  logic [2:0]                   req_prot,
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic                         rsp_timeout,
  output logic [ADDR_W-1:0]            PADDR,
  output logic [NUM_SLAVES-1:0]        PSEL,
  output logic                         PENABLE,
  output logic                         PWRITE,
  output logic [DATA_W-1:0]            PWDATA,
  output logic [DATA_W/8-1:0]          PSTRB,
  output logic [2:0]                   PPROT,
  input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]        PREADY,
  input  logic [NUM_SLAVES-1:0]        PSLVERR
);

  localparam int unsigned SEL_W  = slv_sel_w(NUM_SLAVES);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  apb_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [NUM_SLAVES-1:0] psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]   pstrb_q, pstrb_d;
  logic [2:0]          pprot_q, pprot_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_timeout_q, rsp_timeout_d;

  logic [SEL_W-1:0]    req_idx;
  logic                idx_ok;
  logic                take;
  logic [DATA_W-1:0]   sel_rdata;
  logic                sel_ready;
  logic                sel_slverr;

  if (NUM_SLAVES == 1) begin : g_one
    assign req_idx = '0;
  end else begin : g_dec
    assign req_idx = req_addr[ADDR_W-1 -: SEL_W];
  end

  assign idx_ok = (32'(req_idx) < NUM_SLAVES);

  apb_resp_mux #(
    .NUM_SLAVES (NUM_SLAVES),
    .DATA_W     (DATA_W),
    .SEL_W      (SEL_W)
  ) u_resp_mux (
    .sel_idx (sel_q),
    .prdata  (PRDATA),
    .pready  (PREADY),
    .pslverr (PSLVERR),
    .rdata   (sel_rdata),
    .ready   (sel_ready),
    .slverr  (sel_slverr)
  );

  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    pprot_d       = pprot_q;
    sel_d         = sel_q;
    cnt_d         = cnt_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = '0;
    rsp_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;
    req_ready     = 1'b0;
    take          = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        take      = req_valid;
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (sel_ready) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : sel_rdata;
          rsp_err_d   = sel_slverr;
          // A bad-decode request is not chained here: its DERR pulse would
          // land in the same cycle as this response, so it waits for IDLE.
          if (req_valid && idx_ok) begin
            req_ready = 1'b1;
            take      = 1'b1;
          end else begin
            state_d   = IDLE;
            psel_d    = '0;
            penable_d = 1'b0;
          end
        end else if ((TIMEOUT_CYC > 0) && (cnt_q == CNT_LAST)) begin
          state_d       = IDLE;
          psel_d        = '0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else if (TIMEOUT_CYC > 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (take) begin
      if (idx_ok) begin
        state_d   = SETUP;
        paddr_d   = req_addr;
        pwrite_d  = req_write;
        pwdata_d  = req_wdata;
        pstrb_d   = req_write ? req_strb : '0;
        pprot_d   = req_prot;
        sel_d     = req_idx;
        penable_d = 1'b0;
        cnt_d     = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
          psel_d[i] = (req_idx == SEL_W'(i));
        end
      end else begin
        state_d     = DERR;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      paddr_q       <= '0;
      psel_q        <= '0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
      sel_q         <= '0;
      cnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      pprot_q       <= pprot_d;
      sel_q         <= sel_d;
      cnt_q         <= cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign PADDR       = paddr_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PWDATA      = pwdata_q;
  assign PSTRB       = pstrb_q;
  assign PPROT       = pprot_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: doc/apb_master_mux.md
Name: apb_master_mux

Overview:
Parametrised APB4 master bridge. It takes single-beat read/write requests from a host over a valid/ready interface and drives one APB bus shared by NUM_SLAVES completers, one-hot selected by an upper-address decode. It muxes PRDATA/PREADY/PSLVERR back from the selected completer and returns a one-cycle response pulse. It adds PSTRB/PPROT, a wait-state timeout and back-to-back transfers.

Parameters:
ADDR_W, 9, APB address width
DATA_W, 8, APB data width (multiple of 8)
NUM_SLAVES, 2, completer count (≥1)
TIMEOUT_CYC, 16, max ACCESS wait cycles before abort; 0 disables the timeout

Ports:
PCLK  in  1  clock
PRESETn  in  1  asynchronous active-low reset
req_valid  in  1  host request valid
req_ready  out  1  request accepted when valid&ready
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  write data
req_strb  in  DATA_W/8  write byte strobes
req_prot  in  3  protection attributes
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_W  read data, valid with rsp_valid
rsp_err  out  1  PSLVERR, decode error or timeout
rsp_timeout  out  1  error cause was a timeout
PADDR  out  ADDR_W  APB address
PSEL  out  NUM_SLAVES  one-hot select
PENABLE  out  1  access phase
PWRITE  out  1  direction
PWDATA  out  DATA_W  write data
PSTRB  out  DATA_W/8  strobes; 0 on reads
PPROT  out  3  protection
PRDATA  in  NUM_SLAVES*DATA_W  flattened; slave i at [i*DATA_W +: DATA_W]
PREADY  in  NUM_SLAVES  per-slave ready
PSLVERR  in  NUM_SLAVES  per-slave error

Behaviour:
- Reset (async): state=IDLE. PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, rsp_* all 0. The wait counter clears. A reset mid-transfer drops the bus immediately and produces no response.
- Decode: SEL_W=max(1,$clog2(NUM_SLAVES)); idx=req_addr[ADDR_W-1 -: SEL_W]. If NUM_SLAVES=1, idx is always 0.
- States: IDLE, SETUP, ACCESS, DERR.
  - IDLE: req_ready=1. On accept with idx<NUM_SLAVES, register PADDR/PWRITE/PWDATA/PSTRB (0 if read)/PPROT and PSEL[idx]=1, then go to SETUP. On accept with idx≥NUM_SLAVES, go to DERR and drive no bus activity.
  - SETUP: PENABLE=0 for exactly 1 cycle, then ACCESS.
  - ACCESS: PENABLE=1; all bus outputs stay stable.
    - Completion is PREADY[idx]=1: capture PRDATA slice (reads) and PSLVERR[idx] into rsp_rdata/rsp_err. rsp_valid=1 in the following cycle.
    - After completion: if req_valid is also high, go directly to SETUP for the new request (req_ready=1 combinationally in this cycle only). Otherwise go to IDLE and deassert PSEL/PENABLE.
  - DERR: rsp_valid=1, rsp_err=1, rsp_rdata=0 for one cycle, then IDLE.
- Timeout (TIMEOUT_CYC>0):
  - The counter increments on each ACCESS cycle with PREADY[idx]=0 and clears on entry to SETUP.
  - When the counter reaches TIMEOUT_CYC with no PREADY, abort: PSEL/PENABLE=0 next cycle, state=IDLE, rsp_valid=rsp_err=rsp_timeout=1, rsp_rdata=0.
  - PREADY arriving in the same cycle the limit is hit wins: normal completion.
- Responses: rsp_rdata=0 for writes. rsp_timeout=0 except on timeout. There is no response backpressure; the host must sample rsp_valid.
- Minimum transfer is 2 cycles (SETUP+ACCESS). Back-to-back throughput is one transfer per 2 cycles at zero wait states.
- PREADY/PSLVERR/PRDATA of unselected slaves are ignored.

Decomposition:
- Package apb_pkg: state enum (IDLE, SETUP, ACCESS, DERR), the PPROT bit constants, and a slv_sel_w(NUM_SLAVES) function.
- One sub-module, apb_resp_mux: selects the PRDATA/PREADY/PSLVERR slice by idx. It is combinational.
- The FSM, timeout counter and output registers stay in the top module.

Test Plan:
- Write addr 0x005, data 0xA5, strb 1, zero waits -> PSEL=2'b01 in SETUP; PENABLE next cycle; PWDATA=0xA5, PSTRB=1; rsp_valid 1 cycle later, rsp_err=0.
- Read addr 0x105, slave1 PRDATA=0x3C after 3 wait states -> PSEL=2'b10, PSTRB=0, PENABLE held 4 cycles, rsp_rdata=0x3C.
- Slave0 holds PREADY low with TIMEOUT_CYC=16 -> abort after 16 ACCESS cycles; rsp_err=rsp_timeout=1, bus idle next cycle.
- NUM_SLAVES=3, addr with idx=3 -> no PSEL, DERR response with rsp_err=1 the cycle after accept.
- req_valid held high for 4 writes -> PSEL stays asserted, pattern SETUP/ACCESS repeats, 4 responses 2 cycles apart.
- PRESETn asserted during ACCESS -> all outputs 0 asynchronously, no rsp_valid; the next request after release completes normally.
